// File: rtl/pulse_shaper_pkg.sv
// Shared types and helpers for the pulse shaper.
// Provides the FSM state enum and width helpers.
package pulse_shaper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } pulse_shaper_state_e;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..v-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter used as the pending-event queue depth.
// Ports: clk, reset (async high), inc, dec, clr -> count, full, empty.
module sat_updown_counter #(
    parameter int MAX = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       dec,
    input  logic                       clr,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign full  = (count_q == CW'(MAX));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Simultaneous inc and dec cancel; inc at full and dec at empty are
    // ignored so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec && !full) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_shaper.sv
// Turns single-cycle event strobes into pulses with minimum high time
// and minimum gap; events arriving while busy are queued.
// Ports: clk, reset (async high), enable, trigger -> out (registered),
//        busy, pending (queue depth), overflow (dropped-trigger strobe).
module pulse_shaper
    import pulse_shaper_pkg::*;
#(
    parameter int HIGH_CYCLES = 512,
    parameter int LOW_CYCLES  = 512,
    parameter int MAX_PENDING = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               trigger,
    output logic                               out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int TW = cnt_width(max_u(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [TW-1:0] T_HIGH = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] T_LOW  = TW'(LOW_CYCLES - 1);

    pulse_shaper_state_e state_q;
    pulse_shaper_state_e state_d;
    logic [TW-1:0]       timer_q;
    logic [TW-1:0]       timer_d;
    logic                out_q;
    logic                out_d;

    logic accept;
    logic timer_zero;
    logic gap_done;
    logic q_inc;
    logic q_dec;
    logic q_clr;
    logic q_full;
    logic q_empty;

    assign accept     = enable && trigger;
    assign timer_zero = (timer_q == '0);
    assign gap_done   = (state_q == ST_GAP) && timer_zero;
    assign busy       = (state_q != ST_IDLE);

    // A trigger on the last gap cycle with an empty queue starts the next
    // pulse directly instead of being queued. With a non-empty queue the
    // dequeue and the enqueue cancel inside the counter.
    assign q_inc = accept && busy && !(gap_done && q_empty);
    assign q_dec = gap_done && enable && !q_empty;
    assign q_clr = !enable;

    // A dequeue on the same cycle frees a slot, so that trigger is kept.
    assign overflow = accept && busy && q_full && !q_dec;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HIGH;
                    timer_d = T_HIGH;
                end
            end
            ST_HIGH: begin
                if (timer_zero) begin
                    state_d = ST_GAP;
                    timer_d = T_LOW;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (timer_zero) begin
                    if (enable && (!q_empty || trigger)) begin
                        state_d = ST_HIGH;
                        timer_d = T_HIGH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // out is its own flop so the pad sees a clean registered level.
    assign out_d = (state_d == ST_HIGH);
    assign out   = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
        end
    end

    sat_updown_counter #(
        .MAX (MAX_PENDING)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .inc   (q_inc),
        .dec   (q_dec),
        .clr   (q_clr),
        .count (pending),
        .full  (q_full),
        .empty (q_empty)
    );

endmodule

// File: tb/tb_pulse_shaper.sv
// Self-checking bench for pulse_shaper with a time-window reference model.
// Directed scenarios followed by randomized enable/trigger traffic.
module tb_pulse_shaper;

    localparam int H  = 4;
    localparam int L  = 2;
    localparam int MP = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       trigger;
    logic       out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int total;
    int bad;

    // Reference model: a pulse is described only by the cycle its high
    // phase begins; busy/out/last-gap follow from window arithmetic.
    int ps;
    int pend;
    int cyc;
    int ovf_seen;
    int rises;
    logic prev_out;

    pulse_shaper #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .MAX_PENDING (MP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .trigger  (trigger),
        .out      (out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        ps       = -1000;
        pend     = 0;
        cyc      = 0;
        prev_out = 1'b0;
        ovf_seen = 0;
        rises    = 0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        trigger = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic en, input logic tr);
        logic busy_e;
        logic out_e;
        logic last_e;
        logic acc;
        logic ovf_e;
        enable  = en;
        trigger = tr;
        @(negedge clk);
        busy_e = (cyc >= ps) && (cyc < ps + H + L);
        out_e  = (cyc >= ps) && (cyc < ps + H);
        last_e = busy_e && (cyc == ps + H + L - 1);
        acc    = en && tr;
        ovf_e  = acc && busy_e && (pend == MP) && !(last_e && en);
        chk("out", 32'(out), 32'(out_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("pending", 32'(pending), 32'(pend));
        chk("overflow", 32'(overflow), 32'(ovf_e));
        if (overflow === 1'b1) ovf_seen++;
        if (out === 1'b1 && prev_out !== 1'b1) rises++;
        prev_out = out;
        if (!busy_e) begin
            if (acc) ps = cyc + 1;
        end else if (last_e) begin
            if (en && (pend > 0 || tr)) begin
                ps = cyc + 1;
                if (pend > 0 && !tr) pend--;
            end
        end else if (acc && pend < MP) begin
            pend++;
        end
        if (!en) pend = 0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        trigger = 1'b1;
        model_clear();
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Single trigger.
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        chk("single_rises", 32'(rises), 32'd1);

        // Three back-to-back triggers.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        chk("three_rises", 32'(rises), 32'd3);

        // Five triggers: queue saturates, two dropped.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("sat_ovf", 32'(ovf_seen), 32'd2);
        chk("sat_rises", 32'(rises), 32'd3);

        // Trigger on the last gap cycle with one event queued.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("lastgap_pend", 32'(pending), 32'd1);
        chk("lastgap_out", 32'(out), 32'd1);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
        chk("lastgap_rises", 32'(rises), 32'd3);

        // Disable while a queue is held: flushed, current pulse completes.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("dis_rises", 32'(rises), 32'd1);

        // Reset mid-pulse drops everything at once.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        trigger = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("midrst_rises", 32'(rises), 32'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 10) != 0, ($urandom % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
